// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the shared-ALU arbiter:
//   XLEN             datapath width (RV32I)
//   ALU_ARB_MAX_REQ  largest supported requester count
//   alu_op_t         ALU operation encoding (codes 14/15 are illegal -> result 0)
//   rr_next()        round-robin pointer advance (idx+1 mod n)
//   alu_compute()    single-cycle combinational ALU
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

  localparam int XLEN            = 32;
  localparam int ALU_ARB_MAX_REQ = 8;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_LT   = 4'd3,   // less-than, signed
    ALU_LTU  = 4'd4,   // less-than, unsigned
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11,
    ALU_GE   = 4'd12,  // greater-or-equal, signed
    ALU_GEU  = 4'd13   // greater-or-equal, unsigned
  } alu_op_t;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Combinational ALU. Shifts use only b[4:0]; compares return 0/1.
  // Unknown encodings return 0 so no X ever reaches the response register.
  function automatic logic [XLEN-1:0] alu_compute(input alu_op_t         op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [4:0]      shamt;
    logic [XLEN-1:0] r;
    shamt = b[4:0];
    r     = '0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLL: r = a << shamt;
      ALU_LT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_LTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR: r = a ^ b;
      ALU_SRL: r = a >> shamt;
      ALU_SRA: r = $signed(a) >>> shamt;
      ALU_OR:  r = a | b;
      ALU_AND: r = a & b;
      ALU_EQ:  r = {{(XLEN-1){1'b0}}, (a == b)};
      ALU_NE:  r = {{(XLEN-1){1'b0}}, (a != b)};
      ALU_GE:  r = {{(XLEN-1){1'b0}}, ($signed(a) >= $signed(b))};
      ALU_GEU: r = {{(XLEN-1){1'b0}}, (a >= b)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
// NUM_REQ-way round-robin arbiter. The search starts at r_ptr and the pointer
// moves to one past the winner on every grant, so a requester that stays
// valid is served within NUM_REQ grants.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (pointer -> 0)
//   i_en          arbitration allowed this cycle
//   i_valid       request vector
//   o_grant       one-hot grant (zero when nothing granted)
//   o_grant_vld   a grant was issued
//   o_grant_idx   index of the winner
// -----------------------------------------------------------------------------
module alu_rr_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_grant_vld,
  output logic [ID_W-1:0]    o_grant_idx
);

  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_grant_vld;
  logic [ID_W-1:0]    w_grant_idx;
  int                 w_pos;

  // Walk the ring from r_ptr and keep the first valid requester.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_pos       = 0;
    if (i_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_pos = int'(r_ptr) + i;
        if (w_pos >= NUM_REQ) begin
          w_pos = w_pos - NUM_REQ;
        end
        if (!w_grant_vld && i_valid[w_pos[ID_W-1:0]]) begin
          w_grant_vld                  = 1'b1;
          w_grant_idx                  = w_pos[ID_W-1:0];
          w_grant[w_pos[ID_W-1:0]]     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant_vld) begin
      r_ptr <= ID_W'(rr_next(int'(w_grant_idx), NUM_REQ));
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_vld = w_grant_vld;
  assign o_grant_idx = w_grant_idx;

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between NUM_REQ requesters with round-robin arbitration and a
// single registered response slot (1-cycle latency, full backpressure).
// Optional build macro: ALU_ARB_PERF_EN adds saturating performance counters.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous flush: drops the response, blocks grants
//   req_valid/ready per-requester handshake (req_ready one-hot or zero)
//   req_op/a/b/tag  per-requester operation, operands and opaque tag
//   rsp_valid/ready response handshake
//   rsp_id/tag      owner index and echoed tag of the response
//   rsp_result      registered ALU result, rsp_nonzero = result != 0
//   perf_grants     (ALU_ARB_PERF_EN) grants accepted per requester
//   perf_stalls     (ALU_ARB_PERF_EN) cycles with a request but no grant
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  alu_op_t                    req_op  [NUM_REQ],
  input  logic [XLEN-1:0]            req_a   [NUM_REQ],
  input  logic [XLEN-1:0]            req_b   [NUM_REQ],
  input  logic [TAG_W-1:0]           req_tag [NUM_REQ],
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic [XLEN-1:0]            rsp_result,
  output logic                       rsp_nonzero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]                perf_grants [NUM_REQ],
  output logic [31:0]                perf_stalls
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > ALU_ARB_MAX_REQ) begin : g_bad_num_req
    $error("alu_arbiter: NUM_REQ must be in 2..%0d", ALU_ARB_MAX_REQ);
  end

  logic                w_can_issue;
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_grant_vld;
  logic [ID_W-1:0]     w_grant_idx;
  logic [XLEN-1:0]     w_alu_result;

  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [TAG_W-1:0]    r_rsp_tag;
  logic [XLEN-1:0]     r_rsp_result;
  logic                r_rsp_nonzero;

  // The slot can take a new result when empty or being drained this cycle.
  // rst_n is folded in so req_ready stays low for the whole reset window.
  assign w_can_issue = rst_n && !flush && (!r_rsp_valid || rsp_ready);

  alu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (w_can_issue),
    .i_valid     (req_valid),
    .o_grant     (w_grant),
    .o_grant_vld (w_grant_vld),
    .o_grant_idx (w_grant_idx)
  );

  assign req_ready    = w_grant;
  assign w_alu_result = alu_compute(req_op[w_grant_idx], req_a[w_grant_idx], req_b[w_grant_idx]);

  // Data registers only move on a grant, so they hold while the slot waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_tag     <= '0;
      r_rsp_result  <= '0;
      r_rsp_nonzero <= 1'b0;
    end else if (w_grant_vld) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_id      <= w_grant_idx;
      r_rsp_tag     <= req_tag[w_grant_idx];
      r_rsp_result  <= w_alu_result;
      r_rsp_nonzero <= |w_alu_result;
    end else if (flush || rsp_ready) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_tag     = r_rsp_tag;
  assign rsp_result  = r_rsp_result;
  assign rsp_nonzero = r_rsp_nonzero;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] r_perf_stalls;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf_grant
    logic [31:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_grant[gi] && (r_cnt != 32'hFFFF_FFFF)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
    assign perf_grants[gi] = r_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stalls <= '0;
    end else if ((|req_valid) && !w_grant_vld && (r_perf_stalls != 32'hFFFF_FFFF)) begin
      r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N     = 2;
  localparam int TAG_W = 4;
  localparam longint TWO32 = 64'h1_0000_0000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  alu_op_t              req_op  [N];
  logic [31:0]          req_a   [N];
  logic [31:0]          req_b   [N];
  logic [TAG_W-1:0]     req_tag [N];
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [$clog2(N)-1:0] rsp_id;
  logic [TAG_W-1:0]     rsp_tag;
  logic [31:0]          rsp_result;
  logic                 rsp_nonzero;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]          perf_grants [N];
  logic [31:0]          perf_stalls;
`endif

  alu_arbiter #(.NUM_REQ(N), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_tag     (rsp_tag),
    .rsp_result  (rsp_result),
    .rsp_nonzero (rsp_nonzero)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model -----------------------------------------
  // ALU from arithmetic on 64-bit integers rather than bit operators.
  function automatic logic [31:0] ref_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, d, q, r;
    int sh;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = a[31] ? ua - TWO32 : ua;
    sb = b[31] ? ub - TWO32 : ub;
    sh = int'(ub % 32);
    d  = longint'(1) << sh;
    r  = 0;
    case (op)
      ALU_ADD: r = (ua + ub) % TWO32;
      ALU_SUB: r = (ua - ub + TWO32) % TWO32;
      ALU_SLL: r = (ua * d) % TWO32;
      ALU_SRL: r = ua / d;
      ALU_SRA: begin
        q = sa / d;
        if ((sa % d != 0) && sa < 0) q = q - 1;   // floor division
        r = (q + TWO32) % TWO32;
      end
      ALU_LT:  r = (sa < sb)  ? 1 : 0;
      ALU_LTU: r = (ua < ub)  ? 1 : 0;
      ALU_GE:  r = (sa >= sb) ? 1 : 0;
      ALU_GEU: r = (ua >= ub) ? 1 : 0;
      ALU_EQ:  r = (ua == ub) ? 1 : 0;
      ALU_NE:  r = (ua != ub) ? 1 : 0;
      ALU_XOR: r = {32'b0, a ^ b};
      ALU_OR:  r = {32'b0, a | b};
      ALU_AND: r = {32'b0, a & b};
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  logic        m_valid  = 1'b0;
  int          m_id     = 0;
  logic [3:0]  m_tag    = '0;
  logic [31:0] m_result = '0;
  int          m_last   = N - 1;   // last winner; next search starts after it

  // Expected winner for the current inputs, -1 when nobody is granted.
  function automatic int exp_grant();
    if (!rst_n || flush || (m_valid && !rsp_ready)) return -1;
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_id     <= 0;
      m_tag    <= '0;
      m_result <= '0;
      m_last   <= N - 1;
    end else if (exp_grant() >= 0) begin
      m_valid  <= 1'b1;
      m_id     <= exp_grant();
      m_tag    <= req_tag[exp_grant()];
      m_result <= ref_alu(req_op[exp_grant()], req_a[exp_grant()], req_b[exp_grant()]);
      m_last   <= exp_grant();
    end else if (flush || rsp_ready) begin
      m_valid  <= 1'b0;
    end
  end

  // ---------------- helpers --------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string name);
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = exp_grant();
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk({name, "/req_ready"}, 64'(req_ready), 64'(exp_rdy));
    chk({name, "/rsp_valid"}, 64'(rsp_valid), 64'(m_valid));
    chk({name, "/rsp_id"},    64'(rsp_id),    64'(m_id));
    chk({name, "/rsp_tag"},   64'(rsp_tag),   64'(m_tag));
    chk({name, "/rsp_result"},64'(rsp_result),64'(m_result));
    chk({name, "/rsp_nonzero"},64'(rsp_nonzero), 64'(m_result != 0));
    $display("cyc %s: valid=%b ready=%b rsp_v=%0b id=%0d tag=%0h res=%08h",
             name, req_valid, req_ready, rsp_valid, rsp_id, rsp_tag, rsp_result);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [31:0] held;
    for (int i = 0; i < N; i++) begin
      req_op[i] = ALU_ADD; req_a[i] = '0; req_b[i] = '0; req_tag[i] = '0;
    end

    vecs[0]  = '{ALU_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0};
    vecs[1]  = '{ALU_SUB, 32'h7,         32'h9,         32'hFFFF_FFFE};
    vecs[2]  = '{ALU_LT,  32'hFFFF_FFFF, 32'h1,         32'h1};
    vecs[3]  = '{ALU_SRA, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF};
    vecs[4]  = '{ALU_SRL, 32'h8000_0000, 32'd33,        32'h4000_0000};
    vecs[5]  = '{ALU_GEU, 32'h0,         32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{ALU_SLL, 32'h1,         32'd31,        32'h8000_0000};
    vecs[7]  = '{ALU_LTU, 32'h1,         32'hFFFF_FFFF, 32'h1};
    vecs[8]  = '{ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[9]  = '{ALU_OR,  32'h0000_F000, 32'h0F00_0000, 32'h0F00_F000};
    vecs[10] = '{ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[11] = '{ALU_EQ,  32'h5,         32'h5,         32'h1};
    vecs[12] = '{ALU_NE,  32'h5,         32'h5,         32'h0};
    vecs[13] = '{ALU_GE,  32'hFFFF_FFFB, 32'h3,         32'h0};
    vecs[14] = '{alu_op_t'(4'hF), 32'h1, 32'h2,         32'h0};

    // Reset with every requester asking.
    req_valid = '1;
    rsp_ready = 1'b1;
    tick();
    check_cycle("reset");
    chk("reset/req_ready_zero", 64'(req_ready), 64'h0);
    tick();

    // Release: first grant goes to requester 0.
    rst_n = 1'b1;
    check_cycle("rst_release");
    chk("rst_release/first_grant", 64'(req_ready), 64'h1);
    tick();

    // Single op on requester 1.
    req_valid  = 2'b10;
    req_op[1]  = ALU_ADD; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'h1; req_tag[1] = 4'h5;
    check_cycle("single_issue");
    tick();
    req_valid = '0;
    check_cycle("single_rsp");
    chk("single/rsp_valid",   64'(rsp_valid),   64'h1);
    chk("single/rsp_id",      64'(rsp_id),      64'h1);
    chk("single/rsp_result",  64'(rsp_result),  64'h0);
    chk("single/rsp_nonzero", 64'(rsp_nonzero), 64'h0);
    tick();

    // Table of ALU vectors through requester 1.
    for (int i = 0; i < 15; i++) begin
      req_valid  = 2'b10;
      req_op[1]  = vecs[i].op; req_a[1] = vecs[i].a; req_b[1] = vecs[i].b; req_tag[1] = 4'(i);
      check_cycle("vec_issue");
      tick();
      req_valid = '0;
      check_cycle("vec_rsp");
      chk("vec/result",  64'(rsp_result),  64'(vecs[i].exp));
      chk("vec/nonzero", 64'(rsp_nonzero), 64'(vecs[i].exp != 0));
      chk("vec/tag",     64'(rsp_tag),     64'(i % 16));
      tick();
    end

    // Contention: grants alternate 0,1,0,1.
    req_op[0] = ALU_SUB; req_a[0] = 32'd7;         req_b[0] = 32'd9; req_tag[0] = 4'hA;
    req_op[1] = ALU_LT;  req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd1; req_tag[1] = 4'hB;
    req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      check_cycle("contend");
      chk("contend/grant", 64'(req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      if (c > 0) chk("contend/prev_result", 64'(rsp_result), (c % 2 == 1) ? 64'hFFFF_FFFE : 64'h1);
      tick();
    end

    // Backpressure: slot full, consumer stalled for 3 cycles.
    rsp_ready = 1'b0;
    held = rsp_result;
    for (int c = 0; c < 3; c++) begin
      check_cycle("backpressure");
      chk("bp/no_grant",   64'(req_ready),  64'h0);
      chk("bp/rsp_valid",  64'(rsp_valid),  64'h1);
      chk("bp/stable_res", 64'(rsp_result), 64'(held));
      tick();
    end
    rsp_ready = 1'b1;
    check_cycle("bp_release");
    chk("bp/regrant_same_cycle", 64'(req_ready), 64'h1);
    tick();

    // Flush with a full slot.
    rsp_ready = 1'b0;
    flush     = 1'b1;
    check_cycle("flush");
    chk("flush/no_grant", 64'(req_ready), 64'h0);
    tick();
    flush = 1'b0;
    check_cycle("post_flush");
    chk("flush/dropped",     64'(rsp_valid), 64'h0);
    chk("flush/ptr_unmoved", 64'(req_ready), 64'h2);
    tick();

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int r = 0; r < N; r++) begin
        req_op[r]  = alu_op_t'(4'($urandom_range(0, 15)));
        req_a[r]   = rand_word();
        req_b[r]   = rand_word();
        req_tag[r] = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      check_cycle("random");
      tick();
    end
    flush = 1'b0;

    // Reset mid-operation after a grant to requester 0 moved the pointer.
    req_valid = 2'b01; rsp_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst/async_valid", 64'(rsp_valid), 64'h0);
    chk("midrst/ready_low",   64'(req_ready), 64'h0);
    tick();
    req_valid = 2'b11; rsp_ready = 1'b1;
    rst_n = 1'b1;
    check_cycle("midrst_release");
    chk("midrst/search_from_0", 64'(req_ready), 64'h1);
    tick();

`ifdef ALU_ARB_PERF_EN
    // 10 grants to requester 0, then 2 blocked cycles.
    rst_n = 1'b0; req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
    req_valid = 2'b01; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check_cycle("perf_grant");
      tick();
    end
    rsp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check_cycle("perf_block");
      tick();
    end
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("perf/grants0", 64'(perf_grants[0]), 64'd10);
    chk("perf/grants1", 64'(perf_grants[1]), 64'd0);
    chk("perf/stalls",  64'(perf_stalls),    64'd2);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
